// File: rtl/temporal_lte_array.sv
// N-channel clocked race-logic "a <= b" primitive with its own gamma-cycle counter.
// Define TEMPORAL_LTE_TIMESTAMP_EN to add per-channel q_time/q_valid timestamp outputs.
module temporal_lte_array #(
    parameter int N_CH              = 4,
    parameter int GAMMA_CYCLE_WIDTH = 16,
    parameter int PULSE_WIDTH       = 8,
    parameter int MODE              = 0,
    localparam int CW               = $clog2(GAMMA_CYCLE_WIDTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N_CH-1:0]   a,
    input  logic [N_CH-1:0]   b,
    output logic [N_CH-1:0]   q,
    output logic              gamma_tick,
    output logic [CW-1:0]     cycle_cnt
`ifdef TEMPORAL_LTE_TIMESTAMP_EN
    ,
    output logic [N_CH*CW-1:0] q_time,
    output logic [N_CH-1:0]    q_valid
`endif
);

    localparam int            PCW       = $clog2(PULSE_WIDTH + 1);
    localparam logic [CW-1:0] LAST_SLOT = CW'(GAMMA_CYCLE_WIDTH - 1);
    localparam logic          HIST_INIT = (MODE == 1);
    localparam logic          Q_ACTIVE  = (MODE != 1);
    localparam logic          Q_IDLE    = ~Q_ACTIVE;

    typedef enum logic [1:0] {ARMED, FIRING, BLOCKED, SPENT} ch_state_t;

    logic [CW-1:0]   cnt_reg;
    logic [N_CH-1:0] a_d_reg;
    logic [N_CH-1:0] b_d_reg;
    logic [N_CH-1:0] ev_a;
    logic [N_CH-1:0] ev_b;
    logic            wrap;

    assign wrap       = (cnt_reg == LAST_SLOT);
    assign cycle_cnt  = cnt_reg;
    assign gamma_tick = (cnt_reg == '0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_reg <= '0;
            a_d_reg <= {N_CH{HIST_INIT}};
            b_d_reg <= {N_CH{HIST_INIT}};
        end else begin
            cnt_reg <= wrap ? '0 : cnt_reg + 1'b1;
            // History survives the gamma boundary so a held level is not re-detected.
            a_d_reg <= a;
            b_d_reg <= b;
        end
    end

    generate
        if (MODE == 0) begin : g_rise
            assign ev_a = a & ~a_d_reg;
            assign ev_b = b & ~b_d_reg;
        end else if (MODE == 1) begin : g_fall
            assign ev_a = ~a & a_d_reg;
            assign ev_b = ~b & b_d_reg;
        end else begin : g_pulse
            assign ev_a = a;
            assign ev_b = b;
        end
    endgenerate

    genvar gi;
    generate
        for (gi = 0; gi < N_CH; gi++) begin : g_ch
            ch_state_t      state_reg, state_next;
            logic [PCW-1:0] pcnt_reg, pcnt_next;
            logic           q_reg, q_next;

            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    state_reg <= ARMED;
                    pcnt_reg  <= '0;
                    q_reg     <= Q_IDLE;
                end else begin
                    state_reg <= state_next;
                    pcnt_reg  <= pcnt_next;
                    q_reg     <= q_next;
                end
            end

            always_comb begin
                state_next = state_reg;
                pcnt_next  = pcnt_reg;
                q_next     = Q_IDLE;
                if (wrap) begin
                    // Boundary re-arms and truncates; events seen in the last slot are dropped.
                    state_next = ARMED;
                    pcnt_next  = '0;
                end else begin
                    case (state_reg)
                        ARMED: begin
                            if (ev_a[gi]) begin
                                state_next = FIRING;
                                pcnt_next  = PCW'(PULSE_WIDTH - 1);
                                q_next     = Q_ACTIVE;
                            end else if (ev_b[gi]) begin
                                state_next = BLOCKED;
                            end
                        end
                        FIRING: begin
                            if (pcnt_reg == '0) begin
                                state_next = SPENT;
                            end else begin
                                pcnt_next = pcnt_reg - 1'b1;
                                q_next    = Q_ACTIVE;
                            end
                        end
                        default: begin
                            state_next = state_reg;
                        end
                    endcase
                end
            end

            assign q[gi] = q_reg;

`ifdef TEMPORAL_LTE_TIMESTAMP_EN
            logic [CW-1:0] ts_reg;
            logic          vld_reg;
            logic          fire;

            assign fire = !wrap && (state_reg == ARMED) && ev_a[gi];

            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    ts_reg  <= '0;
                    vld_reg <= 1'b0;
                end else if (wrap) begin
                    ts_reg  <= '0;
                    vld_reg <= 1'b0;
                end else if (fire) begin
                    ts_reg  <= cnt_reg;
                    vld_reg <= 1'b1;
                end
            end

            assign q_time[gi*CW +: CW] = ts_reg;
            assign q_valid[gi]         = vld_reg;
`else
`endif
        end
    endgenerate

endmodule

// File: tb/tb_temporal_lte_array.sv
// Directed bench: rising, falling and pulse-encoded instances driven slot by slot,
// plus an asynchronous reset in the middle of a running pulse.
module tb_temporal_lte_array;

    localparam int G  = 16;
    localparam int CW = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;

    logic [3:0]    a_r, b_r, q_r, a_f, b_f, q_f, a_p, b_p, q_p;
    logic          gt_r, gt_f, gt_p;
    logic [CW-1:0] cc_r, cc_f, cc_p;
`ifdef TEMPORAL_LTE_TIMESTAMP_EN
    logic [4*CW-1:0] qt_r, qt_f, qt_p;
    logic [3:0]      qv_r, qv_f, qv_p;
`endif

    int checks = 0;
    int errors = 0;
    int slot   = 0;

    always #5 clk = ~clk;

    temporal_lte_array #(.N_CH(4), .GAMMA_CYCLE_WIDTH(G), .PULSE_WIDTH(8), .MODE(0)) u_rise (
        .clk(clk), .rst(rst), .a(a_r), .b(b_r), .q(q_r), .gamma_tick(gt_r), .cycle_cnt(cc_r)
`ifdef TEMPORAL_LTE_TIMESTAMP_EN
        , .q_time(qt_r), .q_valid(qv_r)
`endif
    );

    temporal_lte_array #(.N_CH(4), .GAMMA_CYCLE_WIDTH(G), .PULSE_WIDTH(4), .MODE(1)) u_fall (
        .clk(clk), .rst(rst), .a(a_f), .b(b_f), .q(q_f), .gamma_tick(gt_f), .cycle_cnt(cc_f)
`ifdef TEMPORAL_LTE_TIMESTAMP_EN
        , .q_time(qt_f), .q_valid(qv_f)
`endif
    );

    temporal_lte_array #(.N_CH(4), .GAMMA_CYCLE_WIDTH(G), .PULSE_WIDTH(8), .MODE(2)) u_pulse (
        .clk(clk), .rst(rst), .a(a_p), .b(b_p), .q(q_p), .gamma_tick(gt_p), .cycle_cnt(cc_p)
`ifdef TEMPORAL_LTE_TIMESTAMP_EN
        , .q_time(qt_p), .q_valid(qv_p)
`endif
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s slot=%0d got=%0h exp=%0h", tag, slot, got, exp);
        end
    endtask

    task automatic next_slot();
        @(posedge clk);
        slot = (slot + 1) % G;
        @(negedge clk);
    endtask

    initial begin
        logic [3:0] exp_r, exp_f, exp_p;
        a_r = '0; b_r = '0;
        a_f = '1; b_f = '1;
        a_p = '0; b_p = '0;

        repeat (3) @(negedge clk);
        check("rst_q_rise", 32'(q_r), 32'h0);
        check("rst_q_fall", 32'(q_f), 32'hF);
        check("rst_cnt", 32'(cc_r), 32'h0);
        rst  = 1'b1;
        slot = 0;

        // Gamma cycles 0 and 1: scenarios 1-5, then levels held across the boundary.
        for (int g = 0; g < 2; g++) begin
            for (int s = 0; s < G; s++) begin
                int t;
                t = (g == 0) ? s : G - 1;
                a_r = {1'b0, t >= 7, t >= 5, t >= 3};
                b_r = {1'b0, t >= 7, t >= 2, t >= 6};
                a_f = {3'b111, !(t >= 13)};
                b_f = 4'hF;
                a_p = (g == 0) ? {s >= 1 && s <= 9, 1'b0, s == 5, s == 3} : 4'h0;
                b_p = (g == 0) ? {s == 4, 1'b0, s == 2, s == 3} : 4'h0;

                exp_r = {1'b0, g == 0 && s >= 8, 1'b0, g == 0 && s >= 4 && s <= 11};
                exp_f = {3'b111, !(g == 0 && s >= 14)};
                exp_p = {g == 0 && s >= 2 && s <= 9, 2'b00, g == 0 && s >= 4 && s <= 11};
                $display("gamma %0d slot %0d a_r=%b b_r=%b q_r=%b q_f=%b q_p=%b", g, s, a_r, b_r, q_r, q_f, q_p);
                check("cnt", 32'(cc_r), 32'(s));
                check("tick", 32'(gt_r), 32'(s == 0));
                check("q_rise", 32'(q_r), 32'(exp_r));
                check("q_fall", 32'(q_f), 32'(exp_f));
                check("q_pulse", 32'(q_p), 32'(exp_p));
`ifdef TEMPORAL_LTE_TIMESTAMP_EN
                check("qv_rise", 32'(qv_r), 32'({1'b0, g == 0 && s >= 8, 1'b0, g == 0 && s >= 4}));
                check("qt_rise", 32'(qt_r),
                      32'({4'd0, (g == 0 && s >= 8) ? 4'd7 : 4'd0, 4'd0, (g == 0 && s >= 4) ? 4'd3 : 4'd0}));
                check("qv_pulse_blocked", 32'(qv_p[1]), 32'h0);
`endif
                next_slot();
            end
        end

        // Gamma cycle 2: fresh pulses, then asynchronous reset at slot 5 mid-pulse.
        for (int s = 0; s <= 5; s++) begin
            a_r = {3'b000, s >= 2};
            b_r = 4'h0;
            a_f = {3'b111, s < 2};
            $display("gamma 2 slot %0d a_r=%b a_f=%b q_r=%b q_f=%b", s, a_r, a_f, q_r, q_f);
            check("q_rise_g2", 32'(q_r), 32'({3'b000, s >= 3}));
            check("q_fall_g2", 32'(q_f), 32'({3'b111, !(s >= 3)}));
            if (s < 5) next_slot();
        end
        rst = 1'b0;
        #1;
        $display("async reset asserted q_r=%b q_f=%b cnt=%0d", q_r, q_f, cc_r);
        check("async_q_rise", 32'(q_r), 32'h0);
        check("async_q_fall", 32'(q_f), 32'hF);
        check("async_cnt", 32'(cc_r), 32'h0);
        a_r = '0; b_r = '0; a_f = '1; b_f = '1; a_p = '0; b_p = '0;
        repeat (2) @(negedge clk);
        rst  = 1'b1;
        slot = 0;

        // After release every channel must be armed again.
        for (int s = 0; s <= 10; s++) begin
            a_r = {2'b00, s >= 1, 1'b0};
            $display("post-reset slot %0d a_r=%b q_r=%b cnt=%0d", s, a_r, q_r, cc_r);
            check("post_cnt", 32'(cc_r), 32'(s));
            check("post_q_rise", 32'(q_r), 32'({2'b00, s >= 2 && s <= 9, 1'b0}));
`ifdef TEMPORAL_LTE_TIMESTAMP_EN
            check("post_qv", 32'(qv_r), 32'({2'b00, s >= 2, 1'b0}));
            check("post_qt", 32'(qt_r), 32'({8'd0, (s >= 2) ? 4'd1 : 4'd0, 4'd0}));
`endif
            next_slot();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
